// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin scheduler sharing a dual up/down counter (c1/c2)
// among NREQ requesters. Each grant runs a latched burst of en/direction
// cycles; a pending clear takes priority over new grants and is issued through
// start_over. All outputs are registered.
module counter_arbiter #(
   parameter int NREQ = 4,
   parameter int LENW = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        cmd_en1,
   input  logic [NREQ-1:0]        cmd_en2,
   input  logic [NREQ-1:0]        cmd_dir1,
   input  logic [NREQ-1:0]        cmd_dir2,
   input  logic [NREQ*LENW-1:0]   cmd_len,
   input  logic                   clr_req,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        done,
   output logic                   clr_ack,
   output logic                   busy,
   output logic                   start_over,
   output logic                   en1,
   output logic                   en2,
   output logic                   direction1,
   output logic                   direction2
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_CLEAR = 2'd2
   } state_t;

   // Control state
   state_t            r_state;
   logic [PW-1:0]     r_ptr;
   logic [PW-1:0]     r_k;
   logic [LENW-1:0]   r_rem;
   logic              r_clr_pend;
   logic              r_l_en1;
   logic              r_l_en2;
   logic              r_l_dir1;
   logic              r_l_dir2;

   // Registered outputs
   logic [NREQ-1:0]   r_gnt;
   logic [NREQ-1:0]   r_done;
   logic              r_clr_ack;
   logic              r_busy;
   logic              r_start_over;
   logic              r_en1;
   logic              r_en2;
   logic              r_dir1;
   logic              r_dir2;

   // Arbitration and next-state values
   logic              w_found;
   logic [PW-1:0]     w_sel;
   logic [LENW-1:0]   w_len;
   state_t            w_state_nxt;
   logic [PW-1:0]     w_ptr_nxt;
   logic [PW-1:0]     w_k_nxt;
   logic [LENW-1:0]   w_rem_nxt;
   logic              w_clr_pend_nxt;
   logic              w_l_en1_nxt;
   logic              w_l_en2_nxt;
   logic              w_l_dir1_nxt;
   logic              w_l_dir2_nxt;

   // Next output values
   logic [NREQ-1:0]   w_gnt_nxt;
   logic [NREQ-1:0]   w_done_nxt;
   logic              w_clr_ack_nxt;
   logic              w_busy_nxt;
   logic              w_start_over_nxt;
   logic              w_en1_nxt;
   logic              w_en2_nxt;
   logic              w_dir1_nxt;
   logic              w_dir2_nxt;

   // Circular index: (base + off) mod NREQ for base, off < NREQ
   function automatic logic [PW-1:0] f_wrap(input int base, input int off);
      int s;
      s = base + off;
      s = (s >= NREQ) ? (s - NREQ) : s;
      return PW'(s);
   endfunction

   // Find the first requesting index at or after the round-robin pointer;
   // scanning from the far end lets the nearest hit overwrite the others.
   always_comb begin
      w_found = 1'b0;
      w_sel   = PW'(0);
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (req[f_wrap(int'(r_ptr), j)]) begin
            w_found = 1'b1;
            w_sel   = f_wrap(int'(r_ptr), j);
         end else begin
            w_found = w_found;
            w_sel   = w_sel;
         end
      end
   end

   assign w_len = cmd_len[w_sel*LENW +: LENW];

   // Next-state logic: clear beats grants in IDLE, bursts run to completion
   always_comb begin
      w_state_nxt    = r_state;
      w_ptr_nxt      = r_ptr;
      w_k_nxt        = r_k;
      w_rem_nxt      = r_rem;
      w_clr_pend_nxt = r_clr_pend | clr_req;
      w_l_en1_nxt    = r_l_en1;
      w_l_en2_nxt    = r_l_en2;
      w_l_dir1_nxt   = r_l_dir1;
      w_l_dir2_nxt   = r_l_dir2;
      case (r_state)
         S_IDLE: begin
            if (r_clr_pend || clr_req) begin
               w_state_nxt    = S_CLEAR;
               w_clr_pend_nxt = 1'b0;
            end else if (w_found) begin
               w_state_nxt  = S_RUN;
               w_k_nxt      = w_sel;
               w_ptr_nxt    = (w_sel == PW'(NREQ - 1)) ? PW'(0) : (w_sel + PW'(1));
               // a zero-length burst still occupies one RUN cycle, but never steps
               w_rem_nxt    = (w_len == LENW'(0)) ? LENW'(1) : w_len;
               w_l_en1_nxt  = cmd_en1[w_sel] & (w_len != LENW'(0));
               w_l_en2_nxt  = cmd_en2[w_sel] & (w_len != LENW'(0));
               w_l_dir1_nxt = cmd_dir1[w_sel];
               w_l_dir2_nxt = cmd_dir2[w_sel];
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (r_rem <= LENW'(1)) begin
               w_state_nxt = S_IDLE;
               w_rem_nxt   = LENW'(0);
            end else begin
               w_state_nxt = S_RUN;
               w_rem_nxt   = r_rem - LENW'(1);
            end
         end
         S_CLEAR: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_rem_nxt   = LENW'(0);
         end
      endcase
   end

   // Output decode from the upcoming state, so outputs line up with it when registered
   always_comb begin
      w_gnt_nxt        = {NREQ{1'b0}};
      w_done_nxt       = {NREQ{1'b0}};
      w_clr_ack_nxt    = 1'b0;
      w_start_over_nxt = 1'b0;
      w_en1_nxt        = 1'b0;
      w_en2_nxt        = 1'b0;
      w_dir1_nxt       = 1'b0;
      w_dir2_nxt       = 1'b0;
      w_busy_nxt       = (w_state_nxt != S_IDLE);
      case (w_state_nxt)
         S_RUN: begin
            w_gnt_nxt[w_k_nxt] = 1'b1;
            w_done_nxt         = (w_rem_nxt == LENW'(1)) ? w_gnt_nxt : {NREQ{1'b0}};
            w_en1_nxt          = w_l_en1_nxt;
            w_en2_nxt          = w_l_en2_nxt;
            w_dir1_nxt         = w_l_dir1_nxt;
            w_dir2_nxt         = w_l_dir2_nxt;
         end
         S_CLEAR: begin
            w_start_over_nxt = 1'b1;
            w_clr_ack_nxt    = 1'b1;
         end
         S_IDLE: begin
            w_busy_nxt = 1'b0;
         end
         default: begin
            w_busy_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_ptr        <= PW'(0);
         r_k          <= PW'(0);
         r_rem        <= LENW'(0);
         r_clr_pend   <= 1'b0;
         r_l_en1      <= 1'b0;
         r_l_en2      <= 1'b0;
         r_l_dir1     <= 1'b0;
         r_l_dir2     <= 1'b0;
         r_gnt        <= {NREQ{1'b0}};
         r_done       <= {NREQ{1'b0}};
         r_clr_ack    <= 1'b0;
         r_busy       <= 1'b0;
         r_start_over <= 1'b0;
         r_en1        <= 1'b0;
         r_en2        <= 1'b0;
         r_dir1       <= 1'b0;
         r_dir2       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_ptr        <= w_ptr_nxt;
         r_k          <= w_k_nxt;
         r_rem        <= w_rem_nxt;
         r_clr_pend   <= w_clr_pend_nxt;
         r_l_en1      <= w_l_en1_nxt;
         r_l_en2      <= w_l_en2_nxt;
         r_l_dir1     <= w_l_dir1_nxt;
         r_l_dir2     <= w_l_dir2_nxt;
         r_gnt        <= w_gnt_nxt;
         r_done       <= w_done_nxt;
         r_clr_ack    <= w_clr_ack_nxt;
         r_busy       <= w_busy_nxt;
         r_start_over <= w_start_over_nxt;
         r_en1        <= w_en1_nxt;
         r_en2        <= w_en2_nxt;
         r_dir1       <= w_dir1_nxt;
         r_dir2       <= w_dir2_nxt;
      end
   end

   assign gnt        = r_gnt;
   assign done       = r_done;
   assign clr_ack    = r_clr_ack;
   assign busy       = r_busy;
   assign start_over = r_start_over;
   assign en1        = r_en1;
   assign en2        = r_en2;
   assign direction1 = r_dir1;
   assign direction2 = r_dir2;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed scenarios followed by randomized traffic,
// checked every cycle against a schedule-expansion model that turns each
// arbitration decision into a queue of expected output cycles.
module tb_counter_arbiter;
   localparam int NREQ = 4;
   localparam int LENW = 4;
   localparam int LAT  = NREQ * ((1 << LENW) + 1) + 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req, cmd_en1, cmd_en2, cmd_dir1, cmd_dir2;
   logic [NREQ*LENW-1:0] cmd_len;
   logic                 clr_req;
   logic [NREQ-1:0]      gnt, done;
   logic                 clr_ack, busy, start_over, en1, en2, direction1, direction2;

   typedef struct packed {
      logic [NREQ-1:0] gnt;
      logic [NREQ-1:0] done;
      logic en1, en2, d1, d2, so, ack;
   } rec_t;

   rec_t            q[$];
   int              m_ptr;
   logic            m_pend;
   logic [31:0]     c1, c2, m_c1, m_c2;
   int              n_vec, n_fail;
   int              wait_cnt[NREQ];
   bit              chk_lat, auto_drop;
   logic [NREQ-1:0] prev_gnt;
   logic [NREQ-1:0] seen[$];
   logic [NREQ-1:0] exp_order[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   always #5 clk = ~clk;

   counter_arbiter #(.NREQ(NREQ), .LENW(LENW)) dut (
      .clk(clk), .rst(rst), .req(req), .cmd_en1(cmd_en1), .cmd_en2(cmd_en2),
      .cmd_dir1(cmd_dir1), .cmd_dir2(cmd_dir2), .cmd_len(cmd_len), .clr_req(clr_req),
      .gnt(gnt), .done(done), .clr_ack(clr_ack), .busy(busy), .start_over(start_over),
      .en1(en1), .en2(en2), .direction1(direction1), .direction2(direction2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h (vector %0d)", tag, obs, exp, n_vec);
      end
   endtask

   // One clock cycle: compare outputs against the model, advance model, clock.
   task automatic cycle();
      rec_t e;
      rec_t r;
      logic eb;
      int   k, n;
      logic [LENW-1:0] l;
      n_vec++;
      if (q.size() > 0) begin e = q.pop_front(); eb = 1'b1; end
      else begin e = '0; eb = 1'b0; end
      check("gnt", gnt, e.gnt);
      check("done", done, e.done);
      check("en1", en1, e.en1);
      check("en2", en2, e.en2);
      check("direction1", direction1, e.d1);
      check("direction2", direction2, e.d2);
      check("start_over", start_over, e.so);
      check("clr_ack", clr_ack, e.ack);
      check("busy", busy, eb);
      check("gnt_onehot0", $onehot0(gnt), 1'b1);
      check("done_in_gnt", done & ~gnt, 4'b0000);
      check("so_exclusive", start_over & (en1 | en2 | (|gnt)), 1'b0);
      check("en_needs_gnt", (en1 | en2) & ~(|gnt), 1'b0);
      // counter driven by the DUT outputs versus counter driven by the model
      if (start_over) begin c1 = 32'd0; c2 = 32'd0; end
      else begin
         if (en1) c1 = direction1 ? c1 + 32'd1 : c1 - 32'd1;
         if (en2) c2 = direction2 ? c2 + 32'd1 : c2 - 32'd1;
      end
      if (e.so) begin m_c1 = 32'd0; m_c2 = 32'd0; end
      else begin
         if (e.en1) m_c1 = e.d1 ? m_c1 + 32'd1 : m_c1 - 32'd1;
         if (e.en2) m_c2 = e.d2 ? m_c2 + 32'd1 : m_c2 - 32'd1;
      end
      check("c1", c1, m_c1);
      check("c2", c2, m_c2);
      if (gnt != 4'b0000 && prev_gnt == 4'b0000) seen.push_back(gnt);
      prev_gnt = gnt;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i] && !gnt[i] && !rst) wait_cnt[i]++;
         else wait_cnt[i] = 0;
         if (chk_lat) check("latency_ok", (wait_cnt[i] <= LAT), 1'b1);
      end
      // model: decide what the following cycles must look like
      if (rst) begin
         q.delete(); m_ptr = 0; m_pend = 1'b0;
      end else if (eb) begin
         m_pend = m_pend | clr_req;
      end else if (m_pend || clr_req) begin
         r = '0; r.so = 1'b1; r.ack = 1'b1;
         q.push_back(r);
         m_pend = 1'b0;
      end else if (req != 4'b0000) begin
         k = -1;
         for (int j = 0; j < NREQ; j++)
            if (k < 0 && req[(m_ptr + j) % NREQ]) k = (m_ptr + j) % NREQ;
         l = cmd_len[k*LENW +: LENW];
         n = (l == 4'd0) ? 1 : int'(l);
         for (int s = 1; s <= n; s++) begin
            r = '0;
            r.gnt[k] = 1'b1;
            r.done   = (s == n) ? r.gnt : 4'b0000;
            r.en1    = cmd_en1[k] && (l != 4'd0);
            r.en2    = cmd_en2[k] && (l != 4'd0);
            r.d1     = cmd_dir1[k];
            r.d2     = cmd_dir2[k];
            q.push_back(r);
         end
         m_ptr = (k + 1) % NREQ;
      end
      @(posedge clk);
      #1;
      if (auto_drop) req = req & ~e.done;
   endtask

   task automatic rand_inputs(input bit with_ctl);
      logic [31:0] r;
      r = $urandom;
      cmd_len = r[NREQ*LENW-1:0];
      r = $urandom;
      cmd_en1 = r[3:0]; cmd_en2 = r[7:4]; cmd_dir1 = r[11:8]; cmd_dir2 = r[15:12];
      for (int i = 0; i < NREQ; i++) begin
         if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
         else if (req[i] && gnt[i] && $urandom_range(0, 7) == 0) req[i] = 1'b0;
      end
      clr_req = with_ctl && ($urandom_range(0, 39) == 0);
      rst     = with_ctl && ($urandom_range(0, 299) == 0);
   endtask

   initial begin
      n_vec = 0; n_fail = 0; m_ptr = 0; m_pend = 1'b0;
      c1 = 32'd0; c2 = 32'd0; m_c1 = 32'd0; m_c2 = 32'd0;
      chk_lat = 1'b0; auto_drop = 1'b1; prev_gnt = 4'b0000;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      req = 4'b0000; cmd_en1 = 4'b0000; cmd_en2 = 4'b0000; cmd_dir1 = 4'b0000;
      cmd_dir2 = 4'b0000; cmd_len = 16'h0000; clr_req = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      cycle();                       // reset state: everything 0
      rst = 1'b0;

      // single burst: c1 0 -> 5
      cmd_en1 = 4'b0001; cmd_dir1 = 4'b0001; cmd_len = 16'h0005; req = 4'b0001;
      repeat (8) cycle();
      check("t1_c1", c1, 32'd5);
      check("t1_c2", c2, 32'd0);

      // round-robin fairness from reset
      rst = 1'b1; cycle(); rst = 1'b0;
      seen.delete();
      auto_drop = 1'b0; cmd_en1 = 4'b0000; cmd_len = 16'h2222; req = 4'b1111;
      repeat (15) cycle();
      req = 4'b0000; auto_drop = 1'b1;
      check("t2_bursts", seen.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < seen.size()) check("t2_order", seen[i], exp_order[i]);

      // opposite directions with wrap-around
      c1 = 32'd0; c2 = 32'd0; m_c1 = 32'd0; m_c2 = 32'd0;
      cmd_en1 = 4'b0010; cmd_en2 = 4'b0010; cmd_dir1 = 4'b0000; cmd_dir2 = 4'b0010;
      cmd_len = 16'h0030; req = 4'b0010;
      repeat (6) cycle();
      check("t3_c1", c1, 32'hFFFF_FFFD);
      check("t3_c2", c2, 32'd3);

      // clear pulsed in the 2nd cycle of a len=4 burst is deferred
      cmd_en1 = 4'b0001; cmd_dir1 = 4'b0001; cmd_en2 = 4'b0000; cmd_len = 16'h0004;
      req = 4'b0001;
      cycle();
      cycle();
      clr_req = 1'b1; cycle(); clr_req = 1'b0;
      cycle(); cycle();
      check("t4_c1_pre", c1, 32'd1);
      cycle();
      check("t4_so", start_over, 1'b1);
      cycle();
      check("t4_c1", c1, 32'd0);
      check("t4_c2", c2, 32'd0);

      // zero-length burst, then clear and request together
      cmd_en1 = 4'b0100; cmd_dir1 = 4'b0100; cmd_len = 16'h0000; req = 4'b0100;
      cycle();
      check("t5_gnt", gnt, 4'b0100);
      check("t5_done", done, 4'b0100);
      check("t5_en1", en1, 1'b0);
      cycle();
      clr_req = 1'b1; req = 4'b1000; cmd_en2 = 4'b1000; cmd_dir2 = 4'b1000; cmd_len = 16'h1000;
      cycle();
      clr_req = 1'b0;
      check("t5_so", start_over, 1'b1);
      check("t5_gnt_clr", gnt, 4'b0000);
      cycle();
      cycle();
      check("t5_gnt3", gnt, 4'b1000);
      cycle();
      cycle();
      check("t5_c1", c1, 32'd0);
      check("t5_c2", c2, 32'd1);

      // reset in the 3rd cycle of a len=8 burst
      cmd_en1 = 4'b0001; cmd_dir1 = 4'b0001; cmd_en2 = 4'b0000; cmd_len = 16'h0008;
      req = 4'b0001;
      cycle(); cycle(); cycle();
      rst = 1'b1; cycle(); rst = 1'b0;
      check("t6_gnt", gnt, 4'b0000);
      check("t6_done", done, 4'b0000);
      check("t6_busy", busy, 1'b0);
      check("t6_en1", en1, 1'b0);
      req = 4'b0011; cmd_len = 16'h0011;
      cycle();
      check("t6_first", gnt, 4'b0001);
      repeat (6) cycle();

      // random traffic with clears and resets
      for (int i = 0; i < 1200; i++) begin
         rand_inputs(1'b1);
         cycle();
      end
      // random traffic, no clears/resets: starvation bound active
      clr_req = 1'b0; rst = 1'b0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      chk_lat = 1'b1;
      for (int i = 0; i < 1200; i++) begin
         rand_inputs(1'b0);
         cycle();
      end
      chk_lat = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
